// File: rtl/simon_button_input.sv
// Debounced four-button Simon input: synchronizes, priority-selects and debounces one button,
// reporting its code, a held level and one-cycle press/release pulses (latency DEBOUNCE_CYCLES+3).
module simon_button_input #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SimonBtnTL,
  input  logic       SimonBtnTR,
  input  logic       SimonBtnBL,
  input  logic       SimonBtnBR,
  output logic [1:0] color,
  output logic       pressed,
  output logic       press_event,
  output logic       release_event
);

  localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t      state;
  logic [23:0] cnt;
  logic [1:0]  cand;
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [1:0]  raw_sel;
  logic        any;
  logic        held_up;

  // Bit index equals the button code, so sync2[color] is the accepted button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= {SimonBtnBR, SimonBtnBL, SimonBtnTR, SimonBtnTL};
      sync2 <= sync1;
    end
  end

  always_comb begin
    raw_sel = 2'd3;
    if (!sync2[0])      raw_sel = 2'd0;
    else if (!sync2[2]) raw_sel = 2'd2;
    else if (!sync2[1]) raw_sel = 2'd1;
    any     = (sync2 != 4'hF);
    held_up = sync2[color];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cand          <= '0;
      color         <= '0;
      pressed       <= 1'b0;
      press_event   <= 1'b0;
      release_event <= 1'b0;
    end else begin
      press_event   <= 1'b0;
      release_event <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            state <= PRESS_WAIT;
            cand  <= raw_sel;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!any) begin
            state <= IDLE;
          end else if (raw_sel != cand) begin
            cand <= raw_sel;
            cnt  <= '0;
          end else if (cnt == LAST) begin
            state       <= HELD;
            color       <= cand;
            pressed     <= 1'b1;
            press_event <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        HELD: begin
          // Other buttons are deliberately ignored while one is held.
          if (held_up) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!held_up) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state         <= IDLE;
            pressed       <= 1'b0;
            release_event <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_button_input.sv
// Bench for simon_button_input (DEBOUNCE_CYCLES=4): directed scenarios then random button
// activity, every cycle compared against a run-length model of the debounce rules.
module tb_simon_button_input;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'hF;  // {BR,BL,TR,TL}, active low
  logic [1:0] color;
  logic       pressed;
  logic       press_event;
  logic       release_event;

  int errors = 0;
  int checks = 0;
  int pe_seen = 0;
  int re_seen = 0;

  // Reference model: two-sample input delay plus counts of consecutive agreeing samples.
  logic [3:0] m_pipe0 = 4'hF, m_pipe1 = 4'hF;
  bit         m_held = 0;
  logic [1:0] m_col = 0, m_cand = 0;
  int         m_run = 0, m_rrun = 0;
  bit         m_pe = 0, m_re = 0;

  simon_button_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .SimonBtnTL   (btn[0]),
    .SimonBtnTR   (btn[1]),
    .SimonBtnBL   (btn[2]),
    .SimonBtnBR   (btn[3]),
    .color        (color),
    .pressed      (pressed),
    .press_event  (press_event),
    .release_event(release_event)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] prio(input logic [3:0] s);
    if (!s[0]) return 2'd0;
    if (!s[2]) return 2'd2;
    if (!s[1]) return 2'd1;
    return 2'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [1:0] sel;
    m_pe = 0;
    m_re = 0;
    if (reset) begin
      m_pipe0 = 4'hF; m_pipe1 = 4'hF;
      m_held = 0; m_col = 0; m_cand = 0; m_run = 0; m_rrun = 0;
      return;
    end
    s = m_pipe1;
    if (!m_held) begin
      if (s == 4'hF) begin
        m_run = 0;
      end else begin
        sel = prio(s);
        if (m_run > 0 && sel == m_cand) m_run++;
        else begin
          m_run = 1;
          m_cand = sel;
        end
        if (m_run == D + 1) begin
          m_held = 1; m_col = m_cand; m_pe = 1; m_run = 0; m_rrun = 0;
        end
      end
    end else begin
      if (s[m_col]) begin
        m_rrun++;
        if (m_rrun == D + 1) begin
          m_held = 0; m_re = 1; m_run = 0;
        end
      end else begin
        m_rrun = 0;
      end
    end
    m_pipe1 = m_pipe0;
    m_pipe0 = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pressed", 32'(pressed), 32'(m_held));
    chk("color", 32'(color), 32'(m_col));
    chk("press_event", 32'(press_event), 32'(m_pe));
    chk("release_event", 32'(release_event), 32'(m_re));
    chk("no_both_events", 32'(press_event & release_event), 32'd0);
    pe_seen += int'(press_event);
    re_seen += int'(release_event);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    ticks(3);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_color", 32'(color), 32'd0);
    reset = 1'b0;
    ticks(4);

    // BL held: single press pulse D+3 cycles later, color 2
    btn[2] = 1'b0;
    pe_seen = 0;
    ticks(D + 2);
    chk("bl_early", 32'(pe_seen), 32'd0);
    tick();
    chk("bl_pe", 32'(press_event), 32'd1);
    chk("bl_color", 32'(color), 32'd2);
    ticks(5);
    chk("bl_pe_count", 32'(pe_seen), 32'd1);
    chk("bl_pressed", 32'(pressed), 32'd1);
    btn[2] = 1'b1;
    re_seen = 0;
    ticks(D + 3);
    chk("bl_re", 32'(release_event), 32'd1);
    ticks(5);
    chk("bl_re_count", 32'(re_seen), 32'd1);

    // TR glitch of 3 cycles is rejected
    pe_seen = 0;
    btn[1] = 1'b0;
    ticks(3);
    btn[1] = 1'b1;
    ticks(12);
    chk("glitch_pe", 32'(pe_seen), 32'd0);
    chk("glitch_pressed", 32'(pressed), 32'd0);

    // TR then TL two cycles later: one press reporting TL
    pe_seen = 0;
    btn[1] = 1'b0;
    ticks(2);
    btn[0] = 1'b0;
    ticks(15);
    chk("restart_pe_count", 32'(pe_seen), 32'd1);
    chk("restart_color", 32'(color), 32'd0);
    btn = 4'hF;
    ticks(12);

    // BR accepted, 2-cycle release bounce ignored, then steady release
    btn[3] = 1'b0;
    ticks(D + 3);
    chk("br_color", 32'(color), 32'd3);
    re_seen = 0;
    btn[3] = 1'b1;
    ticks(2);
    btn[3] = 1'b0;
    ticks(10);
    chk("bounce_re", 32'(re_seen), 32'd0);
    chk("bounce_pressed", 32'(pressed), 32'd1);
    btn[3] = 1'b1;
    ticks(D + 2);
    chk("br_re_early", 32'(re_seen), 32'd0);
    tick();
    chk("br_re", 32'(release_event), 32'd1);
    chk("br_color_kept", 32'(color), 32'd3);
    ticks(5);

    // TL accepted, BR toggling ignored
    btn[0] = 1'b0;
    ticks(D + 3);
    chk("tl_pe", 32'(press_event), 32'd1);
    pe_seen = 0;
    re_seen = 0;
    for (int i = 0; i < 6; i++) begin
      btn[3] = ~btn[3];
      ticks(3);
    end
    btn[3] = 1'b1;
    ticks(4);
    chk("toggle_events", 32'(pe_seen + re_seen), 32'd0);
    chk("toggle_color", 32'(color), 32'd0);

    // Reset while held: no release, re-debounced press 7 cycles after
    reset = 1'b1;
    tick();
    chk("hrst_pressed", 32'(pressed), 32'd0);
    chk("hrst_re", 32'(release_event), 32'd0);
    reset = 1'b0;
    pe_seen = 0;
    ticks(D + 2);
    chk("hrst_early", 32'(pe_seen), 32'd0);
    tick();
    chk("hrst_pe", 32'(press_event), 32'd1);
    btn = 4'hF;
    ticks(12);

    // Random activity, including bounces shorter than the debounce window
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) btn = 4'hF;
      else btn = 4'($urandom_range(0, 15));
      ticks($urandom_range(1, 12));
    end
    btn = 4'hF;
    ticks(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
